// File: rtl/mem_stage_ctrl_pkg.sv
//------------------------------------------------------------------------------
// mem_stage_ctrl_pkg
// Shared pipeline definitions for the MEM stage: datapath and register-index
// widths, the MEM-stage FSM state encoding, and a small alignment helper.
// No ports (package).
//------------------------------------------------------------------------------
`timescale 1ns/1ps
package mem_stage_ctrl_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    // Raw state encodings; the enum below is built on them so the encoding
    // stays visible to anything that needs to decode the state by value.
    localparam logic [1:0] IDLE_ENC = 2'd0;
    localparam logic [1:0] REQ_ENC  = 2'd1;
    localparam logic [1:0] DONE_ENC = 2'd2;

    typedef enum logic [1:0] {
        IDLE = IDLE_ENC,
        REQ  = REQ_ENC,
        DONE = DONE_ENC
    } mem_state_e;

    // Word accesses only: the two low address bits must be zero.
    function automatic logic is_word_aligned(input logic [1:0] low_bits);
        return (low_bits == 2'b00);
    endfunction

endpackage

// File: rtl/mem_wb_reg.sv
//------------------------------------------------------------------------------
// mem_wb_reg
// MEM/WB pipeline register. Loads the selected write-back value, destination
// register and write enable on every clock edge unless hold is asserted, in
// which case it keeps its contents.
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   hold                keep current contents this cycle
//   next_wb_data/rd/regwrite   values to load
//   wb_data/rd/regwrite        registered outputs toward write-back
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module mem_wb_reg
    import mem_stage_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  hold,
    input  logic [XLEN-1:0]       next_wb_data,
    input  logic [REG_ADDR_W-1:0] next_rd,
    input  logic                  next_regwrite,
    output logic [XLEN-1:0]       wb_data,
    output logic [REG_ADDR_W-1:0] rd,
    output logic                  regwrite
);

    // The register simply follows its inputs whenever the stage is not held,
    // and is cleared to an inert bubble (regwrite=0) by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_data  <= '0;
            rd       <= '0;
            regwrite <= 1'b0;
        end else if (!hold) begin
            wb_data  <= next_wb_data;
            rd       <= next_rd;
            regwrite <= next_regwrite;
        end
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
//------------------------------------------------------------------------------
// mem_stage_ctrl
// MEM-stage controller. Consumes the EX/MEM register, issues data-memory
// accesses over a req/ready bus, stalls upstream stages until the access
// finishes (or times out), selects the write-back value and loads MEM/WB.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   EX_MEM_*                   instruction fields from the EX/MEM register
//   dmem_req/we/addr/wdata     memory request toward the data memory
//   dmem_ready/rdata           memory completion and load data
//   MEM_stall                  freeze all upstream stages this cycle
//   MEM_misaligned             single-cycle flag for an unaligned mem op
//   MEM_bus_err                sticky timeout flag, cleared only by reset
//   MEM_WB_wb_data/rd/regwrite MEM/WB register outputs
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [XLEN-1:0]       EX_MEM_ALU_result,
    input  logic [XLEN-1:0]       EX_MEM_rs2_data,
    input  logic [XLEN-1:0]       EX_MEM_pc,
    input  logic [REG_ADDR_W-1:0] EX_MEM_rd,
    input  logic                  EX_MEM_regwrite,
    input  logic                  EX_MEM_memtoreg,
    input  logic                  EX_MEM_memread,
    input  logic                  EX_MEM_memwrite,
    input  logic                  EX_MEM_unconditional_jmp,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [XLEN-1:0]       dmem_addr,
    output logic [XLEN-1:0]       dmem_wdata,
    input  logic                  dmem_ready,
    input  logic [XLEN-1:0]       dmem_rdata,
    output logic                  MEM_stall,
    output logic                  MEM_misaligned,
    output logic                  MEM_bus_err,
    output logic [XLEN-1:0]       MEM_WB_wb_data,
    output logic [REG_ADDR_W-1:0] MEM_WB_rd,
    output logic                  MEM_WB_regwrite
);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mem_state_e      state;
    logic [CNT_W-1:0] wait_cnt;
    logic [XLEN-1:0] rdata_q;
    logic            kill;
    logic            bus_err_q;

    logic            mem_op;
    logic            aligned;
    logic            misaligned_op;
    logic [XLEN-1:0] wb_data_sel;
    logic            wb_regwrite_sel;

    // Decode of the instruction sitting in EX/MEM. A store wins over a load
    // if both bits are set, which only matters for dmem_we.
    assign mem_op        = EX_MEM_memread | EX_MEM_memwrite;
    assign aligned       = is_word_aligned(EX_MEM_ALU_result[1:0]);
    assign misaligned_op = (state == IDLE) && mem_op && !aligned;

    // The bus fields are direct views of EX/MEM. They stay stable through the
    // whole request because MEM_stall holds the EX/MEM register.
    assign dmem_req   = (state == REQ);
    assign dmem_we    = EX_MEM_memwrite;
    assign dmem_addr  = EX_MEM_ALU_result;
    assign dmem_wdata = EX_MEM_rs2_data;

    // Stall is needed in the launch cycle as well as the request cycles, so
    // it cannot be a pure register. It is gated by reset so that upstream
    // stages are released the moment reset hits, even though EX/MEM may
    // still present a memory instruction.
    assign MEM_stall      = !reset && ((state == REQ) || ((state == IDLE) && mem_op && aligned));
    assign MEM_misaligned = !reset && misaligned_op;
    assign MEM_bus_err    = bus_err_q;

    // Write-back selection. Jumps write the link address, loads write the
    // captured memory data, everything else writes the ALU result. The write
    // enable is suppressed for an access that was rejected as misaligned or
    // abandoned by the timeout.
    always_comb begin
        wb_data_sel = EX_MEM_ALU_result;
        if (EX_MEM_unconditional_jmp) begin
            wb_data_sel = EX_MEM_pc + 32'd4;
        end else if (EX_MEM_memtoreg) begin
            wb_data_sel = rdata_q;
        end
        wb_regwrite_sel = EX_MEM_regwrite;
        if (misaligned_op || ((state == DONE) && kill)) begin
            wb_regwrite_sel = 1'b0;
        end
    end

    // Access sequencer: IDLE launches an aligned access, REQ holds the
    // request until ready or until the wait budget runs out, DONE releases
    // the stall for the one edge that loads MEM/WB. Ready is checked before
    // the timeout so a response on the last allowed cycle still counts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            rdata_q   <= '0;
            kill      <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_op && aligned) begin
                        state    <= REQ;
                        wait_cnt <= '0;
                        kill     <= 1'b0;
                    end
                end
                REQ: begin
                    if (dmem_ready) begin
                        rdata_q <= dmem_rdata;
                        state   <= DONE;
                    end else if (wait_cnt == TIMEOUT_LAST) begin
                        bus_err_q <= 1'b1;
                        rdata_q   <= '0;
                        kill      <= 1'b1;
                        state     <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE: begin
                    kill  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    mem_wb_reg u_mem_wb_reg (
        .clk           (clk),
        .reset         (reset),
        .hold          (MEM_stall),
        .next_wb_data  (wb_data_sel),
        .next_rd       (EX_MEM_rd),
        .next_regwrite (wb_regwrite_sel),
        .wb_data       (MEM_WB_wb_data),
        .rd            (MEM_WB_rd),
        .regwrite      (MEM_WB_regwrite)
    );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
//------------------------------------------------------------------------------
// tb_mem_stage_ctrl
// Directed bench for mem_stage_ctrl with TIMEOUT_CYCLES=4. Single-cycle
// instructions come from a vector table; memory accesses, timeouts and the
// mid-access reset are hand-written sequences.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] EX_MEM_ALU_result;
    logic [31:0] EX_MEM_rs2_data;
    logic [31:0] EX_MEM_pc;
    logic [4:0]  EX_MEM_rd;
    logic        EX_MEM_regwrite;
    logic        EX_MEM_memtoreg;
    logic        EX_MEM_memread;
    logic        EX_MEM_memwrite;
    logic        EX_MEM_unconditional_jmp;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        MEM_stall;
    logic        MEM_misaligned;
    logic        MEM_bus_err;
    logic [31:0] MEM_WB_wb_data;
    logic [4:0]  MEM_WB_rd;
    logic        MEM_WB_regwrite;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        regwrite;
        logic        memtoreg;
        logic        memread;
        logic        memwrite;
        logic        jmp;
        logic        exp_mis;
        logic [31:0] exp_wb;
        logic [4:0]  exp_rd;
        logic        exp_regwrite;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    mem_stage_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(3)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .EX_MEM_ALU_result        (EX_MEM_ALU_result),
        .EX_MEM_rs2_data          (EX_MEM_rs2_data),
        .EX_MEM_pc                (EX_MEM_pc),
        .EX_MEM_rd                (EX_MEM_rd),
        .EX_MEM_regwrite          (EX_MEM_regwrite),
        .EX_MEM_memtoreg          (EX_MEM_memtoreg),
        .EX_MEM_memread           (EX_MEM_memread),
        .EX_MEM_memwrite          (EX_MEM_memwrite),
        .EX_MEM_unconditional_jmp (EX_MEM_unconditional_jmp),
        .dmem_req                 (dmem_req),
        .dmem_we                  (dmem_we),
        .dmem_addr                (dmem_addr),
        .dmem_wdata               (dmem_wdata),
        .dmem_ready               (dmem_ready),
        .dmem_rdata               (dmem_rdata),
        .MEM_stall                (MEM_stall),
        .MEM_misaligned           (MEM_misaligned),
        .MEM_bus_err              (MEM_bus_err),
        .MEM_WB_wb_data           (MEM_WB_wb_data),
        .MEM_WB_rd                (MEM_WB_rd),
        .MEM_WB_regwrite          (MEM_WB_regwrite)
    );

    // Compare one observed value with the bench's expectation and count it.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction in the EX/MEM register.
    task automatic applyStimulus(input logic [31:0] alu, input logic [31:0] rs2, input logic [31:0] pc,
                                 input logic [4:0] rd, input logic rw, input logic m2r,
                                 input logic mr, input logic mw, input logic jmp);
        EX_MEM_ALU_result        = alu;
        EX_MEM_rs2_data          = rs2;
        EX_MEM_pc                = pc;
        EX_MEM_rd                = rd;
        EX_MEM_regwrite          = rw;
        EX_MEM_memtoreg          = m2r;
        EX_MEM_memread           = mr;
        EX_MEM_memwrite          = mw;
        EX_MEM_unconditional_jmp = jmp;
    endtask

    task automatic applyNop();
        applyStimulus(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic vec_t mkVec(input logic [31:0] alu, input logic [31:0] pc, input logic [4:0] rd,
                                   input logic rw, input logic m2r, input logic mr, input logic mw,
                                   input logic jmp, input logic exp_mis, input logic [31:0] exp_wb,
                                   input logic exp_rw);
        vec_t v;
        v.alu = alu; v.pc = pc; v.rd = rd; v.regwrite = rw; v.memtoreg = m2r;
        v.memread = mr; v.memwrite = mw; v.jmp = jmp; v.exp_mis = exp_mis;
        v.exp_wb = exp_wb; v.exp_rd = rd; v.exp_regwrite = exp_rw;
        return v;
    endfunction

    // Drive an already-applied memory instruction through its access. The
    // memory answers on the ready_on-th request cycle (0 = never). Counts
    // stall and request cycles, and checks the bus fields stay put and MEM/WB
    // holds while stalled. Returns just before the edge that loads MEM/WB.
    task automatic memOp(input string name, input int ready_on, input logic [31:0] ready_data,
                         input logic [31:0] exp_addr, input logic exp_we, input logic [31:0] exp_wdata,
                         input logic [31:0] hold_wb, input int exp_req, input int exp_stall);
        int stall_cycles = 0;
        int req_cycles = 0;
        int unstable = 0;
        int hold_err = 0;
        logic finished = 1'b0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (MEM_stall !== 1'b1) begin
                finished = 1'b1;
                break;
            end
            stall_cycles++;
            if (MEM_WB_wb_data !== hold_wb) hold_err++;
            if (dmem_req === 1'b1) begin
                req_cycles++;
                if (dmem_we !== exp_we || dmem_addr !== exp_addr || dmem_wdata !== exp_wdata) unstable++;
                if (req_cycles == ready_on) begin
                    dmem_ready = 1'b1;
                    dmem_rdata = ready_data;
                end
            end
            tick();
            dmem_ready = 1'b0;
            dmem_rdata = 32'h0;
        end
        checkOutput({name, "_finished"}, 32'(finished), 32'd1);
        checkOutput({name, "_req_cycles"}, 32'(req_cycles), 32'(exp_req));
        checkOutput({name, "_stall_cycles"}, 32'(stall_cycles), 32'(exp_stall));
        checkOutput({name, "_bus_stable"}, 32'(unstable), 32'd0);
        checkOutput({name, "_wb_hold"}, 32'(hold_err), 32'd0);
        checkOutput({name, "_req_dropped"}, 32'(dmem_req), 32'd0);
    endtask

    // Check the MEM/WB outputs after the loading edge.
    task automatic checkWb(input string name, input logic [31:0] wb, input logic [4:0] rd, input logic rw);
        checkOutput({name, "_wb_data"}, MEM_WB_wb_data, wb);
        checkOutput({name, "_wb_rd"}, 32'(MEM_WB_rd), 32'(rd));
        checkOutput({name, "_wb_regwrite"}, 32'(MEM_WB_regwrite), 32'(rw));
    endtask

    // Runaway guard.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // alu, pc, rd, rw, m2r, mr, mw, jmp, exp_mis, exp_wb, exp_rw
        vecs[0] = mkVec(32'h0000_1234, 32'h0,         5'd5,  1, 0, 0, 0, 0, 0, 32'h0000_1234, 1);
        vecs[1] = mkVec(32'h0,         32'h0,         5'd0,  0, 0, 0, 0, 0, 0, 32'h0,         0);
        vecs[2] = mkVec(32'h0000_0055, 32'hFFFF_FFFC, 5'd1,  1, 0, 0, 0, 1, 0, 32'h0000_0000, 1);
        vecs[3] = mkVec(32'h0000_0000, 32'h0000_1000, 5'd31, 1, 0, 0, 0, 1, 0, 32'h0000_1004, 1);
        vecs[4] = mkVec(32'h0000_0102, 32'h0,         5'd7,  1, 0, 1, 0, 0, 1, 32'h0000_0102, 0);
        vecs[5] = mkVec(32'h0000_0203, 32'h0,         5'd3,  0, 0, 0, 1, 0, 1, 32'h0000_0203, 0);
        vecs[6] = mkVec(32'hCAFE_F00D, 32'h0,         5'd10, 1, 0, 0, 0, 0, 0, 32'hCAFE_F00D, 1);

        applyNop();
        dmem_ready = 1'b0;
        dmem_rdata = 32'h0;
        #1 reset = 1'b1;
        tick();
        checkOutput("reset_req", 32'(dmem_req), 32'd0);
        checkOutput("reset_stall", 32'(MEM_stall), 32'd0);
        checkOutput("reset_bus_err", 32'(MEM_bus_err), 32'd0);
        checkWb("reset", 32'h0, 5'd0, 1'b0);
        tick();
        reset = 1'b0;

        // Single-cycle instructions: no stall, MEM/WB loads at the next edge.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].alu, 32'h0, vecs[i].pc, vecs[i].rd, vecs[i].regwrite,
                          vecs[i].memtoreg, vecs[i].memread, vecs[i].memwrite, vecs[i].jmp);
            #1;
            checkOutput($sformatf("vec%0d_stall", i), 32'(MEM_stall), 32'd0);
            checkOutput($sformatf("vec%0d_misaligned", i), 32'(MEM_misaligned), 32'(vecs[i].exp_mis));
            checkOutput($sformatf("vec%0d_req", i), 32'(dmem_req), 32'd0);
            tick();
            checkWb($sformatf("vec%0d", i), vecs[i].exp_wb, vecs[i].exp_rd, vecs[i].exp_regwrite);
        end

        // Load, memory answers on the second request cycle.
        applyStimulus(32'h0000_0100, 32'h0, 32'h0, 5'd8, 1, 1, 1, 0, 0);
        memOp("load", 2, 32'hDEAD_BEEF, 32'h0000_0100, 1'b0, 32'h0, 32'hCAFE_F00D, 2, 3);
        tick();
        applyNop();
        checkWb("load", 32'hDEAD_BEEF, 5'd8, 1'b1);

        // Ready outside a request must not disturb the captured load data,
        // which a misaligned load with memtoreg then exposes.
        dmem_ready = 1'b1;
        dmem_rdata = 32'h1111_1111;
        tick();
        dmem_ready = 1'b0;
        dmem_rdata = 32'h0;
        applyStimulus(32'h0000_0301, 32'h0, 32'h0, 5'd12, 1, 1, 1, 0, 0);
        #1;
        checkOutput("mis_load_req", 32'(dmem_req), 32'd0);
        checkOutput("mis_load_flag", 32'(MEM_misaligned), 32'd1);
        tick();
        applyNop();
        checkWb("mis_load", 32'hDEAD_BEEF, 5'd12, 1'b0);
        #1;
        checkOutput("mis_load_flag_drop", 32'(MEM_misaligned), 32'd0);

        // Store, ready on the first request cycle.
        applyStimulus(32'h0000_0104, 32'hA5A5_A5A5, 32'h0, 5'd4, 0, 0, 0, 1, 0);
        memOp("store", 1, 32'h0, 32'h0000_0104, 1'b1, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 1, 2);
        tick();
        applyNop();
        checkWb("store", 32'h0000_0104, 5'd4, 1'b0);

        // Ready on the last allowed request cycle: the response wins.
        applyStimulus(32'h0000_0180, 32'h0, 32'h0, 5'd6, 1, 1, 1, 0, 0);
        memOp("late_ready", 4, 32'h0BAD_F00D, 32'h0000_0180, 1'b0, 32'h0, 32'h0000_0104, 4, 5);
        tick();
        applyNop();
        checkWb("late_ready", 32'h0BAD_F00D, 5'd6, 1'b1);
        checkOutput("late_ready_bus_err", 32'(MEM_bus_err), 32'd0);

        // No response at all: abandoned after four request cycles.
        applyStimulus(32'h0000_0200, 32'h0, 32'h0, 5'd9, 1, 1, 1, 0, 0);
        memOp("timeout", 0, 32'h0, 32'h0000_0200, 1'b0, 32'h0, 32'h0BAD_F00D, 4, 5);
        tick();
        applyNop();
        checkWb("timeout", 32'h0, 5'd9, 1'b0);
        checkOutput("timeout_bus_err", 32'(MEM_bus_err), 32'd1);

        // Pipeline resumes; the error flag stays set.
        applyStimulus(32'h0000_0077, 32'h0, 32'h0, 5'd2, 1, 0, 0, 0, 0);
        #1;
        checkOutput("resume_stall", 32'(MEM_stall), 32'd0);
        tick();
        applyNop();
        checkWb("resume", 32'h0000_0077, 5'd2, 1'b1);
        checkOutput("resume_bus_err_sticky", 32'(MEM_bus_err), 32'd1);

        // Reset in the middle of a request drops req and stall at once.
        applyStimulus(32'h0000_0400, 32'h0, 32'h0, 5'd13, 1, 1, 1, 0, 0);
        tick();
        checkOutput("midreset_req_before", 32'(dmem_req), 32'd1);
        #2 reset = 1'b1;
        #1;
        checkOutput("midreset_req", 32'(dmem_req), 32'd0);
        checkOutput("midreset_stall", 32'(MEM_stall), 32'd0);
        checkOutput("midreset_bus_err", 32'(MEM_bus_err), 32'd0);
        checkOutput("midreset_wb_regwrite", 32'(MEM_WB_regwrite), 32'd0);
        applyNop();
        tick();
        reset = 1'b0;
        tick();
        checkOutput("post_reset_req", 32'(dmem_req), 32'd0);
        checkOutput("post_reset_stall", 32'(MEM_stall), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
